// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM state encoding,
// the row/column to hex-code map, and column-drive helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } scan_state_t;

  // Column 0 driven low, all others released.
  localparam logic [3:0] COL_INIT = 4'b1110;

  // Indexed by {row, col}; entry 15 (row 3, col 3) is listed first.
  localparam logic [15:0][3:0] KEYMAP = {
    4'hD, 4'hF, 4'h0, 4'hE,   // row 3
    4'hC, 4'h9, 4'h8, 4'h7,   // row 2
    4'hB, 4'h6, 4'h5, 4'h4,   // row 1
    4'hA, 4'h3, 4'h2, 4'h1    // row 0
  };

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    return KEYMAP[{row, col}];
  endfunction

  // Lowest-index active-low row wins when several are pressed together.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows_n);
    if (!rows_n[0]) return 2'd0;
    else if (!rows_n[1]) return 2'd1;
    else if (!rows_n[2]) return 2'd2;
    else return 2'd3;
  endfunction

  // Active-low one-cold column drive for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~((~COL_INIT) << idx);
  endfunction

endpackage

// File: rtl/debouncer.sv
// Level debouncer: s_out follows s_in only after s_in has differed from s_out
// for DEBOUNCE_DIVIDER consecutive cycles. Synchronous active-high reset
// forces s_out low.
module debouncer #(
  parameter logic [21:0] DEBOUNCE_DIVIDER = 22'd2_400_000
) (
  input  logic clk,
  input  logic reset,
  input  logic s_in,
  output logic s_out
);

  logic [21:0] cnt_q;
  logic        out_q;

  // Count cycles of disagreement; accept the new level once the count fills.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else if (s_in == out_q) begin
      cnt_q <= '0;
    end else if (cnt_q == DEBOUNCE_DIVIDER - 22'd1) begin
      cnt_q <= '0;
      out_q <= s_in;
    end else begin
      cnt_q <= cnt_q + 22'd1;
    end
  end

  assign s_out = out_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner. Rotates an active-low column drive, latches the
// first pressed row/column, restarts the debouncer for each candidate press,
// and emits a one-cycle key_valid with the hex code on a confirmed press.
// Optional feature macro: KEYPAD_REPEAT_EN enables auto-repeat while held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter logic [15:0] SCAN_DIVIDER     = 16'd48_000,
  parameter logic [21:0] DEBOUNCE_DIVIDER = 22'd2_400_000,
  parameter logic [23:0] REPEAT_DIVIDER   = 24'd12_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned        SCAN_W       = (SCAN_DIVIDER > 16'd1) ? $clog2(SCAN_DIVIDER) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST    = SCAN_W'(SCAN_DIVIDER - 16'd1);
  localparam logic [22:0]       TIMEOUT_LAST = {DEBOUNCE_DIVIDER, 1'b0};

  logic [3:0]        rows_meta, rows_s;
  scan_state_t       state_q, state_d;
  logic [1:0]        col_q, col_d;
  logic [1:0]        row_q, row_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [22:0]       timeout_q, timeout_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              deb_reset, deb_in, deb_out;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [23:0] REPEAT_LAST = REPEAT_DIVIDER - 24'd1;
  logic [23:0] repeat_q, repeat_d;
`else
  // Parameter kept for interface compatibility; no repeat logic in this build.
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_DIVIDER;
`endif

  // Two-flop synchronizer for the asynchronous, pulled-up row inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rows_meta <= 4'hF;
      rows_s    <= 4'hF;
    end else begin
      rows_meta <= rows;
      rows_s    <= rows_meta;
    end
  end

  // The debouncer is held in reset while scanning so every candidate press
  // starts from a clean, released state.
  assign deb_reset = reset | (state_q == SCAN);
  assign deb_in    = ~rows_s[row_q];

  debouncer #(
    .DEBOUNCE_DIVIDER(DEBOUNCE_DIVIDER)
  ) u_debouncer (
    .clk  (clk),
    .reset(deb_reset),
    .s_in (deb_in),
    .s_out(deb_out)
  );

  // Next-state logic for the scan FSM and its counters.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    scan_cnt_d  = scan_cnt_q;
    timeout_d   = timeout_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    repeat_d    = repeat_q;
`endif
    unique case (state_q)
      SCAN: begin
        if (rows_s != 4'hF) begin
          // Freeze the column (col_q unchanged) and start qualifying the press.
          row_d     = lowest_low_row(rows_s);
          timeout_d = '0;
          state_d   = DEBOUNCE;
        end else if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          col_d      = col_q + 2'd1;
        end else begin
          scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end
      end
      DEBOUNCE: begin
        if (deb_out) begin
          key_code_d  = key_lookup(row_q, col_q);
          key_valid_d = 1'b1;
          state_d     = HELD;
`ifdef KEYPAD_REPEAT_EN
          repeat_d    = '0;
`endif
        end else if (timeout_q == TIMEOUT_LAST) begin
          state_d = SCAN;
        end else begin
          timeout_d = timeout_q + 23'd1;
        end
      end
      HELD: begin
        if (!deb_out) begin
          state_d    = SCAN;
          col_d      = 2'd0;
          scan_cnt_d = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        else if (repeat_q == REPEAT_LAST) begin
          key_valid_d = 1'b1;
          repeat_d    = '0;
        end else begin
          repeat_d = repeat_q + 24'd1;
        end
`endif
      end
      default: state_d = SCAN;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      scan_cnt_q  <= '0;
      timeout_q   <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      repeat_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      scan_cnt_q  <= scan_cnt_d;
      timeout_q   <= timeout_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
`ifdef KEYPAD_REPEAT_EN
      repeat_q    <= repeat_d;
`endif
    end
  end

  assign cols      = col_drive(col_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == HELD);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
// Expected key codes are queued when a press is driven and compared when
// key_valid pulses.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [3:0][3:0] pressed;  // [row][col]
  logic [3:0]      exp_q[$];
  int              tests = 0;
  int              fails = 0;
  int              pulse_cnt = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIVIDER    (16'd4),
    .DEBOUNCE_DIVIDER(22'd100),
    .REPEAT_DIVIDER  (24'd300)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rows     (rows),
    .cols     (cols),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // A pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r][c] && (cols[c] == 1'b0)) rows[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (key_valid === 1'b1) begin
        pulse_cnt++;
        check("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("pulse_key_code", 32'(key_code), 32'(exp_q.pop_front()));
        check("pulse_key_held", 32'(key_held), 32'd1);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits for cols to change into v (start of that column's window).
  task automatic wait_cols(input logic [3:0] v, input int max, output bit seen);
    logic [3:0] prev;
    prev = cols;
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      #1;
      if (cols === v && prev !== v) begin
        seen = 1'b1;
        break;
      end
      prev = cols;
    end
  endtask

  task automatic wait_valid(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      #1;
      if (key_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_held_low(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      #1;
      if (key_held === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [3:0] seq[4];
    bit         seen;
    int         base;
    int         n_hold;

    seq     = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    pressed = '0;
    reset   = 1'b1;
    fork
      monitor();
    join_none

    // Reset and idle scan
    repeat (2) @(posedge clk);
    #1;
    check("reset_cols", 32'(cols), 32'(4'b1110));
    check("reset_key_code", 32'(key_code), 32'h0);
    check("reset_key_valid", 32'(key_valid), 32'd0);
    check("reset_key_held", 32'(key_held), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("scan_cols_%0d", i), 32'(cols), 32'(seq[((i + 1) / 4) % 4]));
    end

    // Bounced press of row 1 / col 2 (code 6)
    wait_cols(4'b1011, 40, seen);
    check("bounce_col_found", 32'(seen), 32'd1);
    base = pulse_cnt;
    exp_q.push_back(4'h6);
    #1;
    pressed[1][2] = 1'b1;
    repeat (4) begin
      #15;
      pressed[1][2] = ~pressed[1][2];
    end
    tick(20);
    check("bounce_cols_frozen", 32'(cols), 32'(4'b1011));
    wait_valid(84, seen);
    check("bounce_pulse_seen", 32'(seen), 32'd1);
    check("bounce_key_held", 32'(key_held), 32'd1);
    tick(30);
    check("bounce_one_pulse", 32'(pulse_cnt - base), 32'd1);
    pressed[1][2] = 1'b0;
    wait_held_low(150, seen);
    check("bounce_release_seen", 32'(seen), 32'd1);
    check("bounce_release_cols", 32'(cols), 32'(4'b1110));
    check("bounce_queue_empty", 32'(exp_q.size()), 32'd0);

    // Glitch on row 0 / col 0: no pulse, return to scanning
    wait_cols(4'b1110, 40, seen);
    check("glitch_col_found", 32'(seen), 32'd1);
    base = pulse_cnt;
    pressed[0][0] = 1'b1;
    tick(20);
    pressed[0][0] = 1'b0;
    wait_cols(4'b1101, 250, seen);
    check("glitch_scan_resumed", 32'(seen), 32'd1);
    check("glitch_no_pulse", 32'(pulse_cnt - base), 32'd0);
    check("glitch_key_code_kept", 32'(key_code), 32'h6);

    // Long hold of row 3 / col 1 (code 0)
`ifdef KEYPAD_REPEAT_EN
    n_hold = 3;
`else
    n_hold = 1;
`endif
    wait_cols(4'b1101, 40, seen);
    check("hold_col_found", 32'(seen), 32'd1);
    base = pulse_cnt;
    for (int i = 0; i < n_hold; i++) exp_q.push_back(4'h0);
    pressed[3][1] = 1'b1;
    tick(300);
    check("hold_key_held", 32'(key_held), 32'd1);
    check("hold_cols_frozen", 32'(cols), 32'(4'b1101));
    tick(400);
    pressed[3][1] = 1'b0;
    wait_held_low(150, seen);
    check("hold_release_seen", 32'(seen), 32'd1);
    check("hold_release_cols", 32'(cols), 32'(4'b1110));
    check("hold_pulse_count", 32'(pulse_cnt - base), 32'(n_hold));
    check("hold_queue_empty", 32'(exp_q.size()), 32'd0);

    // Rows 0 and 2 together in column 0, then another key during HELD
    wait_cols(4'b1110, 40, seen);
    check("simul_col_found", 32'(seen), 32'd1);
    base = pulse_cnt;
    exp_q.push_back(4'h1);
    pressed[0][0] = 1'b1;
    pressed[2][0] = 1'b1;
    wait_valid(130, seen);
    check("simul_pulse_seen", 32'(seen), 32'd1);
    tick(2);
    pressed[3][0] = 1'b1;
    tick(150);
    check("simul_no_rollover", 32'(pulse_cnt - base), 32'd1);
    check("simul_still_held", 32'(key_held), 32'd1);
    pressed = '0;
    wait_held_low(150, seen);
    check("simul_release_seen", 32'(seen), 32'd1);
    check("simul_key_code", 32'(key_code), 32'h1);

    // Reset during DEBOUNCE of row 0 / col 3
    wait_cols(4'b0111, 40, seen);
    check("midrst_col_found", 32'(seen), 32'd1);
    base = pulse_cnt;
    pressed[0][3] = 1'b1;
    tick(53);
    check("midrst_cols_frozen", 32'(cols), 32'(4'b0111));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_cols", 32'(cols), 32'(4'b1110));
    check("midrst_key_valid", 32'(key_valid), 32'd0);
    check("midrst_key_held", 32'(key_held), 32'd0);
    pressed = '0;
    reset   = 1'b0;
    wait_cols(4'b1101, 10, seen);
    check("midrst_scan_resumed", 32'(seen), 32'd1);
    tick(200);
    check("midrst_no_pulse", 32'(pulse_cnt - base), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad one column at a time and sequences the existing `debouncer` block. On a confirmed press it emits a single-cycle `key_valid` pulse with a 4-bit hex `key_code`. It sits between the keypad I/O pins and the display/entry logic. It also owns the debouncer's reset and input, restarting it for every candidate press.

## Interface
- `SCAN_DIVIDER`, default 16'd48_000: cycles each column is driven while scanning (1 ms at 48 MHz).
- `DEBOUNCE_DIVIDER`, default 22'd2_400_000: passed to `debouncer`; cycles of stable input to accept a level change.
- `REPEAT_DIVIDER`, default 24'd12_000_000: auto-repeat period. Used only with `KEYPAD_REPEAT_EN`.
- `clk`  input  1  system clock; one clock domain.
- `reset`  input  1  synchronous, active-high reset.
- `rows`  input  4  keypad rows, active-low (pulled up), asynchronous to `clk`.
- `cols`  output  4  column drive, active-low, exactly one bit low at all times.
- `key_code`  output  4  hex code of the most recently accepted key.
- `key_valid`  output  1  one-cycle pulse per accepted key event.
- `key_held`  output  1  high while an accepted key remains debounced-pressed.

## Operation
- `rows` pass through a 2-flop synchronizer. All decisions use the synchronized value `rows_s`.
- FSM states: SCAN, DEBOUNCE, HELD.
- **SCAN:**
  - `cols` rotates 1110 → 1101 → 1011 → 0111 → 1110, advancing every SCAN_DIVIDER cycles.
  - If any `rows_s` bit is low: latch the column index and the lowest-index low row, freeze `cols`, clear the timeout counter, and go to DEBOUNCE.
  - Debouncer reset is `reset | (state==SCAN)`.
- **DEBOUNCE:**
  - Debouncer `s_in` = `~rows_s[latched_row]`.
  - When debouncer `s_out` is 1: register `key_code` = KEYMAP[row][col], pulse `key_valid`, and go to HELD.
  - Timeout counter runs to 2*DEBOUNCE_DIVIDER. On expiry with `s_out` still 0, return to SCAN with no pulse.
- **HELD:**
  - `key_held` = 1 and `cols` stays frozen.
  - When `s_out` falls to 0 (debounced release), go to SCAN, restart at column 0, and clear the scan counter.
  - Presses of other keys in HELD are ignored (no rollover).
- KEYMAP, by row 0..3 and column 0..3:
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: E 0 F D
- Multiple rows low in the scanned column: the lowest row index wins.

## Timing
- Reset values: `cols`=4'b1110, `key_code`=4'h0, `key_valid`=0, `key_held`=0, state=SCAN. All counters are 0.
- Reset is honoured in any state. It takes effect at the next edge and cancels any pending pulse.
- Row-to-FSM latency is 2 cycles (synchronizer).
- `key_valid` rises on the cycle after `s_out` is first sampled as 1. `key_code` changes on that same edge and holds until the next pulse.
- `key_held` rises with `key_valid` and falls on the edge where the state leaves HELD.
- The scan counter width fits SCAN_DIVIDER-1. It wraps to 0 on column advance.
- The timeout counter is 23 bits, so 2*DEBOUNCE_DIVIDER does not overflow.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - A repeat counter in HELD clears on HELD entry.
  - Each time it reaches REPEAT_DIVIDER, it pulses `key_valid` again with an unchanged `key_code` and restarts.
- `KEYPAD_REPEAT_EN` undefined:
  - Exactly one pulse per press and no repeat counter.
  - REPEAT_DIVIDER is accepted but unused.

## Structure
- Package `keypad_pkg` holds:
  - the state enum `scan_state_t` (SCAN, DEBOUNCE, HELD);
  - the 16-entry `KEYMAP` constant;
  - the column-drive constant `COL_INIT` = 4'b1110.
- One sub-module: the existing `debouncer`, instantiated once with `.DEBOUNCE_DIVIDER(DEBOUNCE_DIVIDER)`.
- The synchronizer and counters stay inline.

## Test plan
Bench parameters: SCAN_DIVIDER=4, DEBOUNCE_DIVIDER=100, REPEAT_DIVIDER=300; `clk` period 10.
- **Reset and idle.** Assert reset for 2 cycles with `rows`=1111 → `cols`=1110, `key_code`=0, `key_valid`=0, `key_held`=0. Then `cols` steps 1110, 1101, 1011, 0111 every 4 cycles.
- **Bounced press.** Press row1/col2 with 4 toggles of 15 time units, then hold low → `cols` frozen at 1011. Exactly one `key_valid` pulse, `key_code`=4'h6, within 100+4 cycles of the final edge.
- **Glitch rejection.** Row 0 low for 20 cycles, then released → no `key_valid`. Return to SCAN within 200 cycles of latch, with `key_code` unchanged.
- **Hold and release.** Hold row3/col1 (code 4'h0) for 700 cycles, then release → `key_held`=1 during the hold. It drops about 100 cycles after release, and scanning resumes at 1110. With `KEYPAD_REPEAT_EN`: 3 pulses total. Without: 1 pulse.
- **Simultaneous keys.** Row0 and row2 low together in column 0 → `key_code`=4'h1. A second key pressed during HELD produces no pulse.
- **Reset mid-operation.** Assert reset 50 cycles into DEBOUNCE → next edge `cols`=1110, state SCAN, no `key_valid` ever emitted for that press.
